// File: rtl/mem_arbiter_if.sv
// Wishbone classic bus between the UART bridge (master) and the memory arbiter (slave).
// Signal names keep the arbiter-side _i/_o suffixes on both modports.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic                  m0_cyc_i;
   logic                  m0_stb_i;
   logic                  m0_we_i;
   logic [ADDR_WIDTH-1:0] m0_adr_i;
   logic [DATA_WIDTH-1:0] m0_dat_i;
   logic [DATA_WIDTH-1:0] m0_dat_o;
   logic                  m0_ack_o;

   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      input  m0_dat_o, m0_ack_o
   );

   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      output m0_dat_o, m0_ack_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a single-port SRAM between the core data port and a Wishbone UART bridge.
// The core owns the SRAM in IDLE; a UART access freezes the core for four cycles.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_arbiter_if.slave          m0,
   input  logic                  c_req_i,
   input  logic                  c_we_i,
   input  logic [ADDR_WIDTH-1:0] c_adr_i,
   input  logic [DATA_WIDTH-1:0] c_dat_i,
   output logic [DATA_WIDTH-1:0] c_dat_o,
   output logic                  o_stall,
   output logic                  sram_csb_o,
   output logic                  sram_web_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_din_o,
   input  logic [DATA_WIDTH-1:0] sram_dout_i
);
   typedef enum logic [2:0] {IDLE, U_ISSUE, U_WAIT, U_ACK, U_END} state_t;

   state_t                state_q, state_d;
   logic                  fair_q, fair_d;
   logic                  c_rd_pend_q, c_rd_pend_d;
   logic [DATA_WIDTH-1:0] c_dat_r_q, c_dat_r_d;
   logic [DATA_WIDTH-1:0] m0_dat_q, m0_dat_d;
   logic                  m0_req;
   logic                  m0_ack;

   assign m0_req = m0.m0_cyc_i & m0.m0_stb_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         fair_q      <= 1'b0;
         c_rd_pend_q <= 1'b0;
         c_dat_r_q   <= '0;
         m0_dat_q    <= '0;
      end else begin
         state_q     <= state_d;
         fair_q      <= fair_d;
         c_rd_pend_q <= c_rd_pend_d;
         c_dat_r_q   <= c_dat_r_d;
         m0_dat_q    <= m0_dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         // After a UART transaction the core wins one tie before the UART may go again.
         IDLE:    if (m0_req && !(fair_q && c_req_i)) state_d = U_ISSUE;
         U_ISSUE: state_d = m0.m0_cyc_i ? U_WAIT : IDLE;
         U_WAIT:  state_d = m0.m0_cyc_i ? U_ACK : IDLE;
         U_ACK:   state_d = U_END;
         U_END:   if (!m0.m0_stb_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fair_d = fair_q;
      if (state_q == IDLE && c_req_i) begin
         fair_d = 1'b0;
      end else if (state_q == U_END && !m0.m0_stb_i) begin
         fair_d = 1'b1;
      end
      c_rd_pend_d = (state_q == IDLE) && c_req_i && !c_we_i;
      c_dat_r_d   = c_rd_pend_q ? sram_dout_i : c_dat_r_q;
      m0_dat_d    = (state_q == U_WAIT && !m0.m0_we_i) ? sram_dout_i : m0_dat_q;
   end

   always_comb begin
      sram_csb_o  = 1'b1;
      sram_web_o  = 1'b1;
      sram_addr_o = c_adr_i;
      sram_din_o  = c_dat_i;
      o_stall     = 1'b1;
      m0_ack      = 1'b0;
      unique case (state_q)
         IDLE: begin
            sram_csb_o = ~c_req_i;
            sram_web_o = ~c_we_i;
            o_stall    = 1'b0;
         end
         U_ISSUE: begin
            sram_csb_o  = 1'b0;
            sram_web_o  = ~m0.m0_we_i;
            sram_addr_o = m0.m0_adr_i;
            sram_din_o  = m0.m0_dat_i;
         end
         U_ACK:   m0_ack = m0.m0_cyc_i;
         default: ;
      endcase
   end

   // Read data is forwarded live in the cycle after the read, then held across stalls.
   assign c_dat_o     = c_rd_pend_q ? sram_dout_i : c_dat_r_q;
   assign m0.m0_dat_o = m0_dat_q;
   assign m0.m0_ack_o = m0_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural 1RW SRAM plus cycle-by-cycle expected values.
module tb_mem_arbiter;
   localparam int DW = 32;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we;
   logic [AW-1:0] c_adr;
   logic [DW-1:0] c_dat_w, c_dat_o;
   logic          o_stall;
   logic          sram_csb, sram_web;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;
   logic [DW-1:0] sram_mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_bus),
      .c_req_i     (c_req),
      .c_we_i      (c_we),
      .c_adr_i     (c_adr),
      .c_dat_i     (c_dat_w),
      .c_dat_o     (c_dat_o),
      .o_stall     (o_stall),
      .sram_csb_o  (sram_csb),
      .sram_web_o  (sram_web),
      .sram_addr_o (sram_addr),
      .sram_din_o  (sram_din),
      .sram_dout_i (sram_dout)
   );

   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) sram_mem[sram_addr] <= sram_din;
         else           sram_dout <= sram_mem[sram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      m0_bus.m0_cyc_i = cyc;
      m0_bus.m0_stb_i = stb;
      m0_bus.m0_we_i  = we;
      m0_bus.m0_adr_i = adr;
      m0_bus.m0_dat_i = dat;
   endtask

   task automatic core_cycle(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      c_req = 1'b1; c_we = we; c_adr = adr; c_dat_w = dat;
      tick();
      c_req = 1'b0; c_we = 1'b0;
      $display("core %s adr=%h dat=%h", we ? "write" : "read ", adr, dat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stall_h [0:12];
      logic stb_h   [0:12];
      int   held_slots;
      int   acc_cnt;

      rst = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_dat_w = '0;
      set_m0(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ack",   32'(m0_bus.m0_ack_o), 32'd0);
      check_eq("rst_stall", 32'(o_stall), 32'd0);
      check_eq("rst_c_dat", c_dat_o, 32'h0);
      check_eq("rst_m0_dat", m0_bus.m0_dat_o, 32'h0);
      check_eq("rst_csb",   32'(sram_csb), 32'd1);
      tick();
      rst = 1'b1;

      core_cycle(1'b1, 9'h1FF, 32'h12345678);
      core_cycle(1'b1, 9'h020, 32'hA5A5A5A5);

      // Core write then read of 0x010
      c_req = 1'b1; c_we = 1'b1; c_adr = 9'h010; c_dat_w = 32'hDEADBEEF;
      @(negedge clk);
      check_eq("cw_stall", 32'(o_stall), 32'd0);
      check_eq("cw_csb",   32'(sram_csb), 32'd0);
      check_eq("cw_web",   32'(sram_web), 32'd0);
      tick();
      c_we = 1'b0;
      @(negedge clk);
      check_eq("cr_stall", 32'(o_stall), 32'd0);
      check_eq("cr_web",   32'(sram_web), 32'd1);
      tick();
      c_req = 1'b0;
      @(negedge clk);
      check_eq("cr_data",  c_dat_o, 32'hDEADBEEF);
      check_eq("cr_stall2", 32'(o_stall), 32'd0);
      tick();
      @(negedge clk);
      check_eq("cr_data_hold", c_dat_o, 32'hDEADBEEF);
      tick();
      $display("core write/read 0x010 data=%h", c_dat_o);

      // UART read of 0x1FF with the core idle; grant at k=0
      set_m0(1'b1, 1'b1, 1'b0, 9'h1FF, '0);
      for (int k = 0; k < 7; k++) begin
         if (k == 4) set_m0(1'b0, 1'b0, 1'b0, 9'h1FF, '0);
         @(negedge clk);
         check_eq($sformatf("urd_ack%0d", k),   32'(m0_bus.m0_ack_o), 32'(k == 3));
         check_eq($sformatf("urd_stall%0d", k), 32'(o_stall), 32'(k >= 1 && k <= 4));
         tick();
      end
      check_eq("urd_data", m0_bus.m0_dat_o, 32'h12345678);
      $display("uart read adr=1ff data=%h", m0_bus.m0_dat_o);

      core_cycle(1'b0, 9'h010, '0);

      // Core read of 0x020 in the grant cycle of a UART write to 0x021
      c_req = 1'b1; c_we = 1'b0; c_adr = 9'h020;
      set_m0(1'b1, 1'b1, 1'b1, 9'h021, 32'h0BADF00D);
      for (int k = 0; k < 7; k++) begin
         if (k == 1) c_req = 1'b0;
         if (k == 4) set_m0(1'b0, 1'b0, 1'b0, 9'h021, '0);
         @(negedge clk);
         if (k >= 1) check_eq($sformatf("stl_cdat%0d", k), c_dat_o, 32'hA5A5A5A5);
         check_eq($sformatf("stl_stall%0d", k), 32'(o_stall), 32'(k >= 1 && k <= 4));
         tick();
      end
      $display("uart write adr=021 with core read adr=020 data=%h", c_dat_o);
      core_cycle(1'b0, 9'h021, '0);
      @(negedge clk);
      check_eq("uwr_landed", c_dat_o, 32'h0BADF00D);
      tick();

      // Fairness: core requests every cycle, UART re-strobes right after each transaction
      c_req = 1'b1; c_we = 1'b0; c_adr = 9'h010;
      set_m0(1'b1, 1'b1, 1'b0, 9'h1FF, '0);
      for (int k = 0; k < 13; k++) begin
         if (k == 11) begin
            c_req = 1'b0;
            set_m0(1'b0, 1'b0, 1'b0, 9'h1FF, '0);
         end else begin
            m0_bus.m0_stb_i = !(k == 4 || k == 10);
         end
         @(negedge clk);
         stall_h[k] = o_stall;
         stb_h[k]   = m0_bus.m0_stb_i;
         check_eq($sformatf("fair_ack%0d", k), 32'(m0_bus.m0_ack_o), 32'(k == 3 || k == 9));
         check_eq($sformatf("fair_stall%0d", k), 32'(o_stall),
                  32'((k >= 1 && k <= 4) || (k >= 7 && k <= 10)));
         tick();
      end
      // Idle cycles where the UART was requesting but the core kept the SRAM
      held_slots = 0;
      for (int k = 4; k < 9; k++) begin
         if (!stall_h[k] && stb_h[k] && !stall_h[k+1]) held_slots++;
      end
      check_eq("fair_held_slots", 32'(held_slots), 32'd1);
      $display("uart back-to-back reads with core held slots=%0d", held_slots);

      // Abort: cyc drops in U_WAIT
      core_cycle(1'b0, 9'h010, '0);
      set_m0(1'b1, 1'b1, 1'b0, 9'h1FF, '0);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) set_m0(1'b0, 1'b0, 1'b0, 9'h1FF, '0);
         @(negedge clk);
         check_eq($sformatf("abt_ack%0d", k),   32'(m0_bus.m0_ack_o), 32'd0);
         check_eq($sformatf("abt_stall%0d", k), 32'(o_stall), 32'(k == 1 || k == 2));
         tick();
      end
      $display("uart read aborted in wait state");

      // Reset asserted during U_ACK
      set_m0(1'b1, 1'b1, 1'b0, 9'h1FF, '0);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            rst = 1'b1;
            set_m0(1'b0, 1'b0, 1'b0, 9'h1FF, '0);
            c_req = 1'b1; c_we = 1'b0; c_adr = 9'h010;
         end
         @(negedge clk);
         check_eq($sformatf("rsa_ack%0d", k),   32'(m0_bus.m0_ack_o), 32'(k == 3));
         check_eq($sformatf("rsa_stall%0d", k), 32'(o_stall), 32'(k >= 1 && k <= 3));
         if (k == 3) rst = 1'b0;
         tick();
      end
      c_req = 1'b0;
      $display("uart read interrupted by reset");
      // Post-reset cycle values were checked at k=4 above; verify the cleared registers too
      set_m0(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check_eq("rsa_m0_dat", m0_bus.m0_dat_o, 32'h0);
      check_eq("rsa_core_rd", c_dat_o, 32'hDEADBEEF);
      tick();

      // Reset then first-cycle core access
      rst = 1'b0;
      tick();
      rst = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_adr = 9'h020;
      @(negedge clk);
      check_eq("prst_csb",   32'(sram_csb), 32'd0);
      check_eq("prst_c_dat", c_dat_o, 32'h0);
      tick();
      c_req = 1'b0;

      // Held strobe: stb stays high three cycles after the ack
      acc_cnt = 0;
      set_m0(1'b1, 1'b1, 1'b1, 9'h0AB, 32'hCAFEF00D);
      for (int k = 0; k < 10; k++) begin
         if (k == 7) set_m0(1'b0, 1'b0, 1'b0, 9'h0AB, '0);
         @(negedge clk);
         if (!sram_csb) acc_cnt++;
         check_eq($sformatf("hld_ack%0d", k),   32'(m0_bus.m0_ack_o), 32'(k == 3));
         check_eq($sformatf("hld_stall%0d", k), 32'(o_stall), 32'(k >= 1 && k <= 7));
         tick();
      end
      check_eq("hld_sram_accesses", 32'(acc_cnt), 32'd1);
      $display("uart write adr=0ab with held strobe accesses=%0d", acc_cnt);
      core_cycle(1'b0, 9'h0AB, '0);
      @(negedge clk);
      check_eq("hld_landed", c_dat_o, 32'hCAFEF00D);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
